uart_rx_n: RTL and testbench

UART_RX_N -- requirements
Module: uart_rx_n

---
 rtl/uart_rx_n.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_n.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_n.sv
// uart_rx_n: multi-byte 8N1 UART receiver.
//   Armed by a rising edge on Trig_in while idle. It then collects
//   min(Num, 8) bytes into Buffer, with the first byte received in the most
//   significant occupied byte and the last byte received in Buffer[7:0].
//   A bad stop bit or an inter-byte timeout aborts the message and leaves a
//   sticky flag set.
// Ports:
//   Clock      in   rising-edge clock
//   Reset      in   asynchronous, active-low reset
//   RX         in   serial line (asynchronous, idle high, LSB first)
//   Num[3:0]   in   number of bytes to receive, sampled at arm
//   Trig_in    in   arm request (rising-edge sensitive)
//   Buffer[63:0] out assembled message
//   Count[3:0] out  bytes committed in the current message
//   done       out  one-cycle pulse on successful completion
//   idle       out  high when out of reset and in S_IDLE
//   frame_err  out  sticky, set on a bad stop bit
//   timeout    out  sticky, set when no start bit arrives in time
module uart_rx_n #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned TIMEOUT_CLKS = 4096
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        RX,
  input  logic [3:0]  Num,
  input  logic        Trig_in,
  output logic [63:0] Buffer,
  output logic [3:0]  Count,
  output logic        done,
  output logic        idle,
  output logic        frame_err,
  output logic        timeout
);

  localparam int unsigned CW_T = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned CW_B = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned CW   = (CW_T > CW_B) ? CW_T : CW_B;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] TMO_LOAD  = CW'(TIMEOUT_CLKS);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          rx_s1_q, rx_s2_q;
  logic          trig_prev_q;
  logic          trig_ok_q;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [63:0]   buf_q, buf_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    target_q, target_d;
  logic          ferr_q, ferr_d;
  logic          tflag_q, tflag_d;
  logic          arm;

  // trig_ok_q stays low for the first cycle after reset release so that a
  // Trig_in already high at release is absorbed into trig_prev_q, not armed.
  assign arm = Trig_in & ~trig_prev_q & trig_ok_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      trig_prev_q <= 1'b0;
      trig_ok_q   <= 1'b0;
      tmo_q       <= '0;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      buf_q       <= '0;
      cnt_q       <= '0;
      target_q    <= '0;
      ferr_q      <= 1'b0;
      tflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= RX;
      rx_s2_q     <= rx_s1_q;
      trig_prev_q <= Trig_in;
      trig_ok_q   <= 1'b1;
      tmo_q       <= tmo_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      ferr_q      <= ferr_d;
      tflag_q     <= tflag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    ferr_d    = ferr_q;
    tflag_d   = tflag_q;

    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          buf_d    = '0;
          cnt_d    = '0;
          ferr_d   = 1'b0;
          tflag_d  = 1'b0;
          target_d = (Num > 4'd8) ? 4'd8 : Num;
          tmo_d    = TMO_LOAD;
          state_d  = (Num == 4'd0) ? S_DONE : S_WAIT_START;
        end
      end

      S_WAIT_START: begin
        if (!rx_s2_q) begin
          bit_cnt_d = '0;
          state_d   = S_START;
        end else if (tmo_q <= ONE) begin
          tmo_d   = '0;
          tflag_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q - ONE;
        end
      end

      // Timeout counter is frozen here, so a rejected glitch resumes the
      // remaining wait rather than restarting it.
      S_START: begin
        if (bit_cnt_q == HALF_LAST) begin
          bit_cnt_d = '0;
          if (!rx_s2_q) begin
            bit_idx_d = '0;
            state_d   = S_DATA;
          end else begin
            state_d = S_WAIT_START;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + ONE;
        end
      end

      S_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          shreg_d   = {rx_s2_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + ONE;
        end
      end

      S_STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (rx_s2_q) begin
            buf_d = {buf_q[55:0], shreg_q};
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q + 4'd1) == target_q) begin
              state_d = S_DONE;
            end else begin
              tmo_d   = TMO_LOAD;
              state_d = S_WAIT_START;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + ONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Buffer    = buf_q;
  assign Count     = cnt_q;
  assign frame_err = ferr_q;
  assign timeout   = tflag_q;
  assign done      = (state_q == S_DONE);
  // Gated with Reset so idle reads 0 while reset is held.
  assign idle      = Reset & (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_rx_n.sv
// Testbench for uart_rx_n: table-driven messages plus hand-written corner
// sequences; expected messages are queued at arm time and checked on done.
module tb_uart_rx_n;

  localparam int CPB = 16;
  localparam int TMO = 4096;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        RX;
  logic [3:0]  Num;
  logic        Trig_in;
  logic [63:0] Buffer;
  logic [3:0]  Count;
  logic        done, idle, frame_err, timeout;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;

  typedef struct {
    logic [63:0] b;
    logic [3:0]  c;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0]       num;
    int               nb;
    logic [0:7][7:0]  data;
    logic [63:0]      exp_buf;
    logic [3:0]       exp_cnt;
  } vec_t;
  vec_t vecs[5];

  uart_rx_n #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .RX        (RX),
    .Num       (Num),
    .Trig_in   (Trig_in),
    .Buffer    (Buffer),
    .Count     (Count),
    .done      (done),
    .idle      (idle),
    .frame_err (frame_err),
    .timeout   (timeout)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge Clock) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("done_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_buffer", Buffer, e.b);
        chk("sb_count", 64'(Count), 64'(e.c));
      end
    end
  end

  function automatic vec_t mk(input logic [3:0] n, input int nb, input logic [63:0] d,
                              input logic [63:0] eb, input logic [3:0] ec);
    vec_t v;
    v.num = n; v.nb = nb; v.data = d; v.exp_buf = eb; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic arm(input logic [3:0] n);
    Num = n;
    Trig_in = 1'b1;
    @(negedge Clock);
    Trig_in = 1'b0;
    @(negedge Clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (CPB) @(negedge Clock);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge Clock);
    end
    RX = stop;
    repeat (CPB) @(negedge Clock);
    RX = 1'b1;
  endtask

  task automatic wait_done(input int d0, input string name);
    for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge Clock);
    repeat (4) @(negedge Clock);
    chk(name, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int d0;
    exp_t e;

    vecs[0] = mk(4'd2, 2, {8'hA5, 8'h3C, 48'h0}, 64'h0000_0000_0000_A53C, 4'd2);
    vecs[1] = mk(4'd9, 8, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708, 4'd8);
    vecs[2] = mk(4'd1, 1, {8'hFF, 56'h0}, 64'h0000_0000_0000_00FF, 4'd1);
    vecs[3] = mk(4'd3, 3, {8'h00, 8'h80, 8'h7E, 40'h0}, 64'h0000_0000_0000_807E, 4'd3);
    vecs[4] = mk(4'd8, 8, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 4'd8);

    Reset = 1'b0; RX = 1'b1; Num = '0; Trig_in = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_idle", 64'(idle), 64'd0);
    chk("rst_buffer", Buffer, 64'd0);
    chk("rst_count", 64'(Count), 64'd0);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    chk("post_rst_idle", 64'(idle), 64'd1);
    chk("post_rst_done", 64'(done), 64'd0);

    // Table-driven messages
    foreach (vecs[k]) begin
      d0 = done_cnt;
      e.b = vecs[k].exp_buf; e.c = vecs[k].exp_cnt;
      sb.push_back(e);
      arm(vecs[k].num);
      for (int j = 0; j < vecs[k].nb; j++) begin
        send_byte(vecs[k].data[j], 1'b1);
        repeat (3) @(negedge Clock);
      end
      wait_done(d0, "vec_done_once");
      chk("vec_idle", 64'(idle), 64'd1);
      chk("vec_ferr", 64'(frame_err), 64'd0);
      chk("vec_tmo", 64'(timeout), 64'd0);
    end

    // Num = 0: immediate done, line activity ignored
    d0 = done_cnt;
    e.b = '0; e.c = '0;
    sb.push_back(e);
    arm(4'd0);
    chk("num0_done_fast", 64'(done_cnt - d0), 64'd1);
    RX = 1'b0;
    repeat (40) @(negedge Clock);
    RX = 1'b1;
    repeat (5) @(negedge Clock);
    chk("num0_idle", 64'(idle), 64'd1);
    chk("num0_buffer", Buffer, 64'd0);
    chk("num0_count", 64'(Count), 64'd0);
    chk("num0_no_more_done", 64'(done_cnt - d0), 64'd1);

    // Short low glitch rejected before a valid byte
    d0 = done_cnt;
    e.b = 64'h55; e.c = 4'd1;
    sb.push_back(e);
    arm(4'd1);
    RX = 1'b0;
    repeat (4) @(negedge Clock);
    RX = 1'b1;
    repeat (30) @(negedge Clock);
    send_byte(8'h55, 1'b1);
    wait_done(d0, "glitch_done_once");
    chk("glitch_ferr", 64'(frame_err), 64'd0);

    // Bad stop bit on the second byte
    d0 = done_cnt;
    arm(4'd2);
    send_byte(8'h11, 1'b1);
    repeat (3) @(negedge Clock);
    send_byte(8'h22, 1'b0);
    repeat (6) @(negedge Clock);
    chk("ferr_flag", 64'(frame_err), 64'd1);
    chk("ferr_count", 64'(Count), 64'd1);
    chk("ferr_buffer", Buffer, 64'h11);
    chk("ferr_idle", 64'(idle), 64'd1);
    chk("ferr_no_done", 64'(done_cnt - d0), 64'd0);
    e.b = 64'h9A; e.c = 4'd1;
    sb.push_back(e);
    arm(4'd1);
    chk("rearm_clears_ferr", 64'(frame_err), 64'd0);
    send_byte(8'h9A, 1'b1);
    wait_done(d0, "rearm_done_once");

    // Reset mid data bit of the second byte
    arm(4'd2);
    send_byte(8'hC3, 1'b1);
    repeat (3) @(negedge Clock);
    chk("pre_rst_count", 64'(Count), 64'd1);
    chk("pre_rst_buffer", Buffer, 64'hC3);
    RX = 1'b0;
    repeat (CPB) @(negedge Clock);
    RX = 1'b1;
    repeat (5) @(negedge Clock);
    d0 = done_cnt;
    #2;
    Reset = 1'b0;
    Trig_in = 1'b1;
    #1;
    chk("midrst_buffer", Buffer, 64'd0);
    chk("midrst_count", 64'(Count), 64'd0);
    chk("midrst_flags", 64'({done, idle, frame_err, timeout}), 64'd0);
    repeat (3) @(negedge Clock);
    chk("inrst_outputs", 64'({done, idle, frame_err, timeout, Count}), 64'd0);
    Reset = 1'b1;
    repeat (5) @(negedge Clock);
    chk("held_trig_no_arm", 64'(idle), 64'd1);
    Trig_in = 1'b0;
    repeat (2) @(negedge Clock);

    // Timeout after a fresh arm with the line idle
    arm(4'd1);
    repeat (TMO - 96) @(negedge Clock);
    chk("tmo_not_early", 64'(timeout), 64'd0);
    for (int i = 0; i < 300 && timeout !== 1'b1; i++) @(negedge Clock);
    chk("tmo_flag", 64'(timeout), 64'd1);
    repeat (2) @(negedge Clock);
    chk("tmo_idle", 64'(idle), 64'd1);
    chk("tmo_no_done", 64'(done_cnt - d0), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
